fp_sqrt: RTL

- Iterative IEEE-754 square-root unit. It responds to the same start_i/done_o request protocol as the sequential divider.
- Produces an unrounded result struct that is fed to fp_rnd.
- One result bit per cycle, using a restoring digit recurrence.
- Sits beside fp_div in the FPU execution stage and shares its operand, format and result conventions.

---
 rtl/fp_sqrt.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_sqrt.sv
// ---------------------------------------------------------------------------
// fp_sqrt_pkg / fp_sqrt
//
// Iterative IEEE-754 square root with a restoring digit recurrence, one result
// bit per cycle. Produces an unrounded result that is handed to fp_rnd.
// Sequence: IDLE -> PREP -> ITER (M+3 cycles) -> DONE -> IDLE.
//
// Ports
//   clk_i          clock
//   reset_i        asynchronous reset, active-high
//   a_i            radicand, sampled only when start_i is accepted in IDLE
//   start_i        request, accepted only in IDLE
//   busy_o         high from the cycle after acceptance until done_o
//   urnd_result_o  unrounded result (sign, biased exponent, significand with
//                  guard/round/sticky, flags, special-result pass-through)
//   done_o         single-cycle pulse, urnd_result_o valid in this cycle
// ---------------------------------------------------------------------------
package fp_sqrt_pkg;

   typedef enum logic {FP32} fp_format_e;

   function automatic int exp_w(fp_format_e f);
      case (f)
         FP32:    return 8;
         default: return 8;
      endcase
   endfunction

   function automatic int man_w(fp_format_e f);
      case (f)
         FP32:    return 23;
         default: return 23;
      endcase
   endfunction

   localparam int EXP_W = exp_w(FP32);
   localparam int MAN_W = man_w(FP32);
   localparam int FP_W  = 1 + EXP_W + MAN_W;

   // sig = {hidden, fraction, guard, round, sticky}; exp is biased with two
   // spare bits so fp_rnd can detect range problems without wrapping.
   typedef struct packed {
      logic                sign;
      logic [EXP_W+1:0]    exp;
      logic [MAN_W+3:0]    sig;
      logic                invalid;
      logic                overflow;
      logic                underflow;
      logic                special;      // fp_rnd passes special_val through unchanged
      logic [FP_W-1:0]     special_val;
   } uround_res_t;

endpackage

module fp_sqrt
   import fp_sqrt_pkg::*;
#(
   parameter fp_format_e FP_FORMAT = FP32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [FP_W-1:0]   a_i,
   input  logic              start_i,
   output logic              busy_o,
   output uround_res_t       urnd_result_o,
   output logic              done_o
);

   localparam int E      = exp_w(FP_FORMAT);
   localparam int M      = man_w(FP_FORMAT);
   localparam int W      = 1 + E + M;
   localparam int ROOT_W = M + 3;
   localparam int REM_W  = M + 6;
   localparam int RAD_W  = 2 * M + 6;
   localparam int XW     = E + 2;
   localparam int LZ_W   = $clog2(M);
   localparam int CNT_W  = $clog2(M + 4);

   localparam logic signed [XW-1:0] BIAS  = XW'((1 << (E - 1)) - 1);
   localparam logic [CNT_W-1:0]     ITERS = CNT_W'(M + 3);
   localparam logic [W-1:0]         QNAN  = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_e;

   state_e                    state_q, state_d;
   logic [W-1:0]              a_q, a_d;
   logic [RAD_W-1:0]          rad_q, rad_d;
   logic signed [REM_W-1:0]   rem_q, rem_d;
   logic [ROOT_W-1:0]         root_q, root_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [XW-1:0]             exp_q, exp_d;
   uround_res_t               res_q, res_d;

   // ---------------- operand classification ----------------
   logic          sgn, ex_max, ex_zero, fr_zero;
   logic          is_nan, is_snan, is_inf, is_zero, is_special, spec_inv;
   logic [E-1:0]  ex;
   logic [M-1:0]  fr;
   logic [W-1:0]  spec_val;

   assign sgn        = a_q[W-1];
   assign ex         = a_q[W-2:M];
   assign fr         = a_q[M-1:0];
   assign ex_max     = &ex;
   assign ex_zero    = ~|ex;
   assign fr_zero    = ~|fr;
   assign is_nan     = ex_max & ~fr_zero;
   assign is_snan    = is_nan & ~fr[M-1];
   assign is_inf     = ex_max & fr_zero;
   assign is_zero    = ex_zero & fr_zero;
   assign is_special = is_nan | is_inf | is_zero | sgn;
   // A NaN is only invalid when signalling; any other negative non-zero is.
   assign spec_inv   = is_snan | (sgn & ~is_zero & ~is_nan);
   // +inf and both zeros return the operand itself; everything else is qNaN.
   assign spec_val   = (is_nan | (sgn & ~is_zero)) ? QNAN : a_q;

   // ---------------- normalisation ----------------
   logic [LZ_W-1:0]         lz;
   logic [M:0]              sig_n;
   logic signed [XW-1:0]    e_unb, exp_res;
   logic [RAD_W-1:0]        rad_init;

   // NOTE: every always_comb output gets a default before any branch so that
   // no path leaves it unassigned and a latch is never inferred.
   always_comb begin
      lz = '0;
      for (int i = 0; i < M; i++) begin
         if (fr[i]) lz = LZ_W'(M - 1 - i);   // last hit is the leading one
      end
      if (ex_zero) begin
         sig_n = ({1'b0, fr} << lz) << 1;
         e_unb = -BIAS - $signed({{(XW-LZ_W){1'b0}}, lz});
      end else begin
         sig_n = {1'b1, fr};
         e_unb = $signed({2'b00, ex}) - BIAS;
      end
      // Odd exponent: move one factor of 2 into the significand so the
      // radicand lies in [1,4); arithmetic shift then floors e to e/2 exactly.
      rad_init = e_unb[0] ? {sig_n, {(M+5){1'b0}}}
                          : {1'b0, sig_n, {(M+4){1'b0}}};
      exp_res  = (e_unb >>> 1) + BIAS;
   end

   // ---------------- recurrence step ----------------
   logic [REM_W+1:0]   rem_sh, sub_val;
   logic               trial_ok, last_iter;
   logic [REM_W-1:0]   rem_nxt;
   logic [ROOT_W-1:0]  root_nxt;

   assign rem_sh    = {rem_q, rad_q[RAD_W-1 -: 2]};        // bring down 2 bits
   assign sub_val   = {3'b000, root_q, 2'b01};              // 4*root + 1
   assign trial_ok  = rem_sh >= sub_val;
   assign rem_nxt   = trial_ok ? REM_W'(rem_sh - sub_val) : REM_W'(rem_sh);
   assign root_nxt  = {root_q[ROOT_W-2:0], trial_ok};
   assign last_iter = (cnt_q == CNT_W'(1));

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = PREP;
         PREP:    state_d = is_special ? DONE : ITER;
         ITER:    if (last_iter) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample the same pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_o = (state_q == PREP) || (state_q == ITER);
      done_o = (state_q == DONE);
   end

   assign urnd_result_o = res_q;

   // ---------------- datapath next state ----------------
   always_comb begin
      a_d    = a_q;
      rad_d  = rad_q;
      rem_d  = rem_q;
      root_d = root_q;
      cnt_d  = cnt_q;
      exp_d  = exp_q;
      res_d  = res_q;
      unique case (state_q)
         IDLE: if (start_i) a_d = a_i;
         PREP: begin
            if (is_special) begin
               res_d             = '0;
               res_d.sign        = is_zero & sgn;
               res_d.invalid     = spec_inv;
               res_d.special     = 1'b1;
               res_d.special_val = spec_val;
            end else begin
               rad_d  = rad_init;
               rem_d  = '0;
               root_d = '0;
               cnt_d  = ITERS;
               exp_d  = exp_res;
            end
         end
         ITER: begin
            rad_d  = {rad_q[RAD_W-3:0], 2'b00};
            rem_d  = rem_nxt;
            root_d = root_nxt;
            cnt_d  = cnt_q - CNT_W'(1);
            // Radicand in [1,4) keeps the root's top bit at 1: no renormalising.
            if (last_iter) begin
               res_d     = '0;
               res_d.exp = exp_q;
               res_d.sig = {root_nxt, |rem_nxt};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         a_q    <= '0;
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         exp_q  <= '0;
         res_q  <= '0;
      end else begin
         a_q    <= a_d;
         rad_q  <= rad_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         cnt_q  <= cnt_d;
         exp_q  <= exp_d;
         res_q  <= res_d;
      end
   end

endmodule
